// File: rtl/pipe_pkg.sv
// Shared definitions for the CPU pipeline stage registers: stage occupancy
// encoding, the bubble instruction and per-boundary payload widths.
package pipe_pkg;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } stage_state_e;

   typedef enum logic [1:0] {
      B_FD,
      B_DE,
      B_EM,
      B_MW
   } pipe_boundary_e;

   localparam logic [31:0] NOP_INSTR = 32'h0;

   // F/D carries instr + PC + PC+4; later boundaries carry decoded/ALU results.
   function automatic int payload_w(input pipe_boundary_e b);
      case (b)
         B_FD:    return 96;
         B_DE:    return 160;
         B_EM:    return 128;
         default: return 72;
      endcase
   endfunction

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Valid/ready/payload bundle between two pipeline stages.
interface pipe_stage_reg_if
   import pipe_pkg::*;
#(
   parameter int DATA_W = payload_w(B_FD)
);
   logic              valid;
   logic              ready;
   logic [DATA_W-1:0] data;

   modport master (output valid, output data, input ready);
   modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter for performance-debug events.
module sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   output logic [CNT_W-1:0] cnt
);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt <= '0;
      end else if (en && (cnt != '1)) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/pipe_stage_reg.sv
// Parametrised pipeline stage register with valid/ready handshake, hazard stall,
// flush-to-bubble, optional 2-entry skid buffer and a stall-cycle counter.
module pipe_stage_reg
   import pipe_pkg::*;
#(
   parameter int                DATA_W    = payload_w(B_FD),
   parameter logic [DATA_W-1:0] RESET_VAL = DATA_W'(NOP_INSTR),
   parameter bit                SKID_EN   = 1'b1,
   parameter int                CNT_W     = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  stall,
   input  logic                  flush,
   pipe_stage_reg_if.slave       up,
   pipe_stage_reg_if.master      dn,
   output logic [1:0]            occupancy,
   output logic [CNT_W-1:0]      stall_cnt
);

   stage_state_e      state_q, state_d;
   logic [DATA_W-1:0] data_p0;
   logic [DATA_W-1:0] skid_data_p0;
   logic              vld_p0;
   logic              in_ready;
   logic              xfer_in, xfer_out;
   logic              load_main, load_skid, skid_to_main;

   assign vld_p0    = (state_q != ST_EMPTY);
   assign xfer_in   = up.valid & in_ready;
   assign xfer_out  = vld_p0 & dn.ready & ~stall;

   assign up.ready  = in_ready;
   assign dn.valid  = vld_p0;
   assign dn.data   = data_p0;
   assign occupancy = state_q;

   always_comb begin
      state_d      = state_q;
      load_main    = 1'b0;
      load_skid    = 1'b0;
      skid_to_main = 1'b0;
      unique case (state_q)
         ST_EMPTY: begin
            if (xfer_in) begin
               state_d   = ST_ONE;
               load_main = 1'b1;
            end
         end
         ST_ONE: begin
            if (xfer_in && xfer_out) begin
               load_main = 1'b1;
            end else if (xfer_in) begin
               state_d   = ST_TWO;
               load_skid = 1'b1;
            end else if (xfer_out) begin
               state_d = ST_EMPTY;
            end
         end
         ST_TWO: begin
            if (xfer_out) begin
               state_d      = ST_ONE;
               skid_to_main = 1'b1;
            end
         end
         default: state_d = ST_EMPTY;
      endcase
      // Flush outranks everything, including a concurrent stall or transfer-in.
      if (flush) begin
         state_d      = ST_EMPTY;
         load_main    = 1'b0;
         load_skid    = 1'b0;
         skid_to_main = 1'b0;
      end
   end

   // Stage boundary: main register drives the downstream stage.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_EMPTY;
         data_p0 <= RESET_VAL;
      end else begin
         state_q <= state_d;
         if (state_d == ST_EMPTY) begin
            data_p0 <= RESET_VAL;
         end else if (load_main) begin
            data_p0 <= up.data;
         end else if (skid_to_main) begin
            data_p0 <= skid_data_p0;
         end
      end
   end

   if (SKID_EN) begin : g_skid
      logic in_ready_q;
      // in_ready is the registered form of !skid_valid & !stall, so the skid
      // absorbs the single word already accepted when backpressure first rises.
      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            in_ready_q   <= 1'b0;
            skid_data_p0 <= RESET_VAL;
         end else begin
            in_ready_q <= (state_d != ST_TWO) & ~stall;
            if (load_skid) begin
               skid_data_p0 <= up.data;
            end
         end
      end
      assign in_ready = in_ready_q;
   end else begin : g_noskid
      assign in_ready     = ~stall & (~vld_p0 | dn.ready);
      assign skid_data_p0 = RESET_VAL;
   end

   sat_counter #(
      .CNT_W (CNT_W)
   ) u_stall_cnt (
      .clk   (clk),
      .reset (reset),
      .en    (stall & vld_p0),
      .cnt   (stall_cnt)
   );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: a skid-buffered instance and a
// single-register instance with a narrow stall counter.
module tb_pipe_stage_reg;
   import pipe_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        a_reset = 1'b0, a_stall = 1'b0, a_flush = 1'b0;
   logic [1:0]  a_occ;
   logic [15:0] a_cnt;
   logic        b_reset = 1'b0, b_stall = 1'b0, b_flush = 1'b0;
   logic [1:0]  b_occ;
   logic [3:0]  b_cnt;

   pipe_stage_reg_if #(.DATA_W(96)) a_up ();
   pipe_stage_reg_if #(.DATA_W(96)) a_dn ();
   pipe_stage_reg_if #(.DATA_W(96)) b_up ();
   pipe_stage_reg_if #(.DATA_W(96)) b_dn ();

   pipe_stage_reg #(.DATA_W(96), .SKID_EN(1'b1), .CNT_W(16)) dut_a (
      .clk       (clk),
      .reset     (a_reset),
      .stall     (a_stall),
      .flush     (a_flush),
      .up        (a_up),
      .dn        (a_dn),
      .occupancy (a_occ),
      .stall_cnt (a_cnt)
   );

   pipe_stage_reg #(.DATA_W(96), .SKID_EN(1'b0), .CNT_W(4)) dut_b (
      .clk       (clk),
      .reset     (b_reset),
      .stall     (b_stall),
      .flush     (b_flush),
      .up        (b_up),
      .dn        (b_dn),
      .occupancy (b_occ),
      .stall_cnt (b_cnt)
   );

   int checks = 0;
   int failures = 0;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      a_up.valid = 1'b0; a_up.data = '0; a_dn.ready = 1'b0;
      b_up.valid = 1'b0; b_up.data = '0; b_dn.ready = 1'b0;

      // Reset held for two edges
      tick(); tick();
      chk("rst_a_valid", a_dn.valid, 0);
      chk("rst_a_data", a_dn.data, 0);
      chk("rst_a_occ", a_occ, 0);
      chk("rst_a_cnt", a_cnt, 0);
      chk("rst_a_in_ready", a_up.ready, 0);
      chk("rst_b_cnt", b_cnt, 0);
      a_reset = 1'b1; b_reset = 1'b1;
      tick();
      chk("rel_a_in_ready", a_up.ready, 1);

      // Fill with 1-cycle latency
      a_up.valid = 1'b1; a_up.data = 96'hA; a_dn.ready = 1'b1;
      tick();
      chk("fill_valid", a_dn.valid, 1);
      chk("fill_data", a_dn.data, 96'hA);
      chk("fill_occ", a_occ, 1);
      chk("fill_in_ready", a_up.ready, 1);
      a_up.valid = 1'b0;
      tick();
      chk("drain_valid", a_dn.valid, 0);
      chk("drain_data", a_dn.data, 0);

      // Backpressure into the skid
      a_dn.ready = 1'b0; a_up.valid = 1'b1; a_up.data = 96'hB;
      tick();
      chk("skid_one_occ", a_occ, 1);
      chk("skid_one_data", a_dn.data, 96'hB);
      a_up.data = 96'hC;
      tick();
      chk("skid_two_occ", a_occ, 2);
      chk("skid_two_in_ready", a_up.ready, 0);
      chk("skid_two_data", a_dn.data, 96'hB);
      a_up.data = 96'hD;
      tick();
      chk("skid_hold_occ", a_occ, 2);
      chk("skid_hold_data", a_dn.data, 96'hB);
      a_up.valid = 1'b0; a_dn.ready = 1'b1;
      tick();
      chk("skid_pop_data", a_dn.data, 96'hC);
      chk("skid_pop_occ", a_occ, 1);
      chk("skid_pop_in_ready", a_up.ready, 1);
      tick();
      chk("skid_empty_valid", a_dn.valid, 0);
      chk("skid_empty_occ", a_occ, 0);

      // Simultaneous in and out in ONE
      a_up.valid = 1'b1; a_up.data = 96'hE;
      tick();
      chk("inout_first", a_dn.data, 96'hE);
      a_up.data = 96'hF;
      tick();
      chk("inout_data", a_dn.data, 96'hF);
      chk("inout_occ", a_occ, 1);
      a_up.valid = 1'b0;
      tick();
      chk("inout_drain_occ", a_occ, 0);

      // Stall hold
      a_up.valid = 1'b1; a_up.data = 96'h1234;
      tick();
      chk("stall_load", a_dn.data, 96'h1234);
      a_up.valid = 1'b0; a_stall = 1'b1;
      tick();
      chk("stall_cnt1", a_cnt, 1);
      chk("stall_in_ready", a_up.ready, 0);
      tick(); tick(); tick();
      chk("stall_cnt4", a_cnt, 4);
      chk("stall_data", a_dn.data, 96'h1234);
      chk("stall_valid", a_dn.valid, 1);
      a_stall = 1'b0;
      tick();
      chk("unstall_valid", a_dn.valid, 0);
      chk("unstall_cnt", a_cnt, 4);

      // Flush beats stall and drops the incoming word
      a_dn.ready = 1'b0; a_up.valid = 1'b1; a_up.data = 96'h11;
      tick();
      a_up.data = 96'h22;
      tick();
      chk("flush_pre_occ", a_occ, 2);
      a_flush = 1'b1; a_stall = 1'b1; a_up.data = 96'h33;
      tick();
      chk("flush_valid", a_dn.valid, 0);
      chk("flush_occ", a_occ, 0);
      chk("flush_data", a_dn.data, 0);
      chk("flush_cnt", a_cnt, 5);
      a_flush = 1'b0; a_stall = 1'b0; a_up.valid = 1'b0;
      tick();
      chk("flush_after_valid", a_dn.valid, 0);

      // Asynchronous reset between edges
      a_up.valid = 1'b1; a_up.data = 96'h44;
      tick();
      a_up.data = 96'h55;
      tick();
      chk("areset_pre_occ", a_occ, 2);
      a_up.valid = 1'b0;
      #2 a_reset = 1'b0;
      #1;
      chk("areset_occ", a_occ, 0);
      chk("areset_valid", a_dn.valid, 0);
      chk("areset_data", a_dn.data, 0);
      chk("areset_cnt", a_cnt, 0);
      chk("areset_in_ready", a_up.ready, 0);
      tick();
      a_reset = 1'b1;
      tick();
      chk("areset_rel_in_ready", a_up.ready, 1);

      // Single-register variant
      b_dn.ready = 1'b1; b_up.valid = 1'b1; b_up.data = 96'hAA;
      #1;
      chk("b_comb_ready", b_up.ready, 1);
      tick();
      chk("b_valid", b_dn.valid, 1);
      chk("b_data", b_dn.data, 96'hAA);
      b_up.valid = 1'b0;
      tick();
      chk("b_drain", b_dn.valid, 0);
      b_up.valid = 1'b1; b_up.data = 96'hBB;
      tick();
      b_up.data = 96'hCC;
      tick();
      chk("b_replace_data", b_dn.data, 96'hCC);
      chk("b_replace_occ", b_occ, 1);
      b_up.valid = 1'b0; b_dn.ready = 1'b0;
      #1;
      chk("b_bp_in_ready", b_up.ready, 0);
      b_dn.ready = 1'b1; b_stall = 1'b1;
      #1;
      chk("b_stall_in_ready", b_up.ready, 0);
      repeat (14) tick();
      chk("b_cnt14", b_cnt, 14);
      repeat (6) tick();
      chk("b_cnt_sat", b_cnt, 15);
      chk("b_sat_data", b_dn.data, 96'hCC);
      chk("b_sat_valid", b_dn.valid, 1);
      b_stall = 1'b0;
      #1;
      chk("b_unstall_in_ready", b_up.ready, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
